// File: rtl/ars_pipe_stage.sv
// One slot of the elastic pipeline: holds a valid bit and a data word.
// Latency: one cycle from up_* to v/d when the slot is ready.
// Backpressure: ready when empty or when the downstream slot can take our word.
//
// Ports:
//   clk, r_n            clock, async active-low reset
//   flush               synchronous clear (valid always, data when CLEAR_DATA)
//   up_valid, up_data   word offered by the previous slot (or the block input)
//   dn_ready            next slot (or the block output) can take our word
//   v, d                slot contents
//   rdy                 this slot can load from upstream this cycle
module ars_pipe_stage #(
    parameter int WIDTH      = 32,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             v,
    output logic [WIDTH-1:0] d,
    output logic             rdy
);

    // An empty slot never blocks, so bubbles are squeezed out under stall.
    assign rdy = ~v | dn_ready;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            v <= 1'b0;
            d <= '0;
        end else if (flush) begin
            v <= 1'b0;
            if (CLEAR_DATA) begin
                d <= '0;
            end
        end else if (rdy) begin
            v <= up_valid;
            // A bubble moving in leaves the old data in place.
            if (up_valid) begin
                d <= up_data;
            end
        end
    end

endmodule

// File: rtl/ars_pipe_reg.sv
// DEPTH-stage elastic pipeline register with bubble collapse, flush and occupancy count.
// Latency: DEPTH cycles input to output when unstalled; one word per cycle throughput.
// Backpressure: valid/ready; in_ready is combinational through the slot ready chain.
//
// Ports:
//   clk, r_n               clock, async active-low reset
//   flush                  synchronous clear of every slot and the count
//   in_valid/in_ready/in_data     upstream handshake
//   out_valid/out_ready/out_data  downstream handshake (last slot)
//   count                  number of occupied slots, 0..DEPTH
module ars_pipe_reg #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 4,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                       clk,
    input  logic                       r_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]            v;
    logic [DEPTH-1:0][WIDTH-1:0] d;
    logic                        in_xfer;
    logic                        out_xfer;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;
        logic             dn_rdy;
        logic             rdy_w;

        if (i == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = v[i-1];
            assign up_d = d[i-1];
        end

        // Each slot's ready lives in its own generate scope so the ready
        // chain is a plain wire cascade rather than a self-referencing vector.
        if (i == DEPTH - 1) begin : g_tail
            assign dn_rdy = out_ready;
        end else begin : g_link
            assign dn_rdy = g_stage[i+1].rdy_w;
        end

        ars_pipe_stage #(
            .WIDTH      (WIDTH),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_stage (
            .clk      (clk),
            .r_n      (r_n),
            .flush    (flush),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (dn_rdy),
            .v        (v[i]),
            .d        (d[i]),
            .rdy      (rdy_w)
        );
    end

    assign in_ready  = g_stage[0].rdy_w;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Flush wins over any transfer in the same cycle; a word leaving during
    // the flush cycle has already been taken by downstream.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
        end else if (!in_xfer && out_xfer) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: doc/ars_pipe_reg.md
Name: ars_pipe_reg

Overview:
- Parametrised successor to the single-stage clear-able data register.
- DEPTH-stage, WIDTH-bit elastic pipeline register with per-stage valid bits and valid/ready backpressure.
- Bubbles collapse: a stalled output does not block stages that are empty.
- Synchronous flush, matching the existing synchronous-clear register semantics.
- Occupancy count output.
- Used between SHA-1 round/schedule datapath stages and anywhere a retimable, stallable delay line is needed.

Parameters:
- WIDTH, 32: data width in bits, ≥1.
- DEPTH, 4: number of register stages, ≥1.
- CLEAR_DATA, 1:
  - 1: flush also zeroes the data registers.
  - 0: flush clears valid bits only; data registers hold.

Ports:
- clk  input  1  rising-edge clock.
- r_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of all stages, active-high.
- in_valid  input  1  upstream presents in_data.
- in_ready  output  1  pipeline can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  stage DEPTH-1 holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  data of stage DEPTH-1.
- count  output  $clog2(DEPTH+1)  number of valid stages, 0..DEPTH.

Behaviour:
- **Reset (r_n low, asynchronous):**
  - All valid bits = 0, all data registers = 0, count = 0.
  - Resulting outputs: out_valid = 0, out_data = 0, in_ready = 1.
  - Deassertion is synchronised externally; the block assumes clean release.
- **Stage model.** Stage i (0..DEPTH-1) holds v[i] and d[i].
  - Stage ready: rdy[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - For i < DEPTH-1: rdy[i] = !v[i] | rdy[i+1].
  - in_ready = rdy[0]. This is a combinational path through the chain and is accepted for DEPTH ≤ 8.
- **Per clock edge, when flush = 0 and rdy[i] = 1:**
  - Stage i loads from stage i-1: v[i] <= v[i-1], d[i] <= d[i-1].
  - Stage 0 loads from the input: v[0] <= in_valid, d[0] <= in_data.
  - When rdy[i] = 0, stage i holds.
- **Data gating.** d[i] updates only when the incoming valid is 1. A bubble moving in does not overwrite data.
- **Transfers.**
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- **Latency.** With out_ready held high, data accepted at edge n appears on out_data after edge n+DEPTH-1, i.e. DEPTH register stages. Throughput is one word per cycle.
- **Occupancy count.** count <= count + in_xfer - out_xfer. Simultaneous in and out transfer leaves count unchanged. count never exceeds DEPTH.
- **Full condition.**
  - When count = DEPTH and out_ready = 0: in_ready = 0.
  - When count = DEPTH and out_ready = 1: in_ready = 1, and the pipeline accepts while draining.
- **Empty condition.** When count = 0, out_valid = 0 and out_data holds its last value. The bench must not check out_data in this state.
- **Flush (synchronous, priority over all movement):**
  - At the edge: all v <= 0 and count <= 0.
  - If CLEAR_DATA = 1, all d <= 0.
  - Input offered in the flush cycle is dropped. in_ready still reflects pre-flush state in that cycle.
  - Output presented in the flush cycle is considered consumed if out_ready = 1. The downstream sees it transfer; no retraction occurs.
- **Reset mid-operation.** Asynchronous clear takes effect immediately regardless of flush or handshake state.
- **Invariant.** out_data is stable while out_valid = 1 and out_ready = 0.

Decomposition:
- No shared package needed. The count width is computed locally with $clog2.
- One natural sub-module: **ars_pipe_stage**, with parameters WIDTH and CLEAR_DATA, holding v/d for one stage.
  - Inputs: clk, r_n, flush, up_valid, up_data, dn_ready.
  - Outputs: v, d, rdy.
- Instantiate it DEPTH times in a generate loop. The count register stays in the top level.

Test Plan:
1. **Streaming.** Reset, then DEPTH=4, out_ready=1, push 0x00000001..0x00000008 on consecutive cycles.
   - Required: out_data emits 1..8 in order, first word 4 edges after the first acceptance.
   - Required: count holds at 4 in steady state.
2. **Backpressure fill.** out_ready=0, push 0xA0..0xA5.
   - Required: first 4 accepted (count=4); in_ready=0 from then on; 0xA4 held at the input.
   - Then out_ready=1: required output order A0,A1,A2,A3,A4,A5 with no loss or duplicate.
3. **Bubble collapse.** Push a single word 0x55, wait 1 cycle, push 0x66, with out_ready=0 throughout.
   - Required: both words compact into stages 3 and 2, count=2, in_ready stays 1.
4. **Flush.** With 3 valid words, assert flush for one cycle while in_valid=1 with 0x77.
   - Required: next cycle count=0, out_valid=0, and 0x77 is never emitted.
   - Required: with CLEAR_DATA=1, every stage's data register reads 0 after the flush.
5. **Asynchronous reset.** Pull r_n low mid-stream, between clock edges.
   - Required: out_valid=0, out_data=0, count=0 immediately, before the next edge.
6. **Simultaneous in/out at full.** count=4, out_ready=1, in_valid=1 with 0xBEEF.
   - Required: count stays 4; 0xBEEF appears at the output after the 3 older words.
